// File: rtl/clk_divider_multi.sv
// N-channel programmable clock divider / tick generator with a valid/ready
// configuration port. Divisor and mode updates apply only at a period boundary.
module clk_divider_multi #(
    parameter int N_CH         = 4,
    parameter int WIDTH        = 28,
    parameter int DEFAULT_DIV  = 125_000_000,
    parameter int DEFAULT_MODE = 0,
    parameter int CLK_INIT     = 1,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset_n,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             cfg_err,
    output logic [N_CH-1:0]  div_clk,
    output logic [N_CH-1:0]  tick
);

    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
    localparam logic             MODE_RST = (DEFAULT_MODE != 0);
    localparam logic             CLK_RST  = (CLK_INIT != 0);
    localparam logic [CH_W:0]    N_CH_L   = (CH_W + 1)'(N_CH);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr;
    logic            ch_ok;
    logic            div_ok;
    logic            cfg_fire;

    // Handshake: a transfer happens on a clock edge where cfg_valid && cfg_ready.
    // cfg_ready depends only on cfg_ch and registered pending bits, never on
    // cfg_valid; an out-of-range channel is always ready so the reject completes.
    always_comb begin
        ch_ok     = ({1'b0, cfg_ch} < N_CH_L);
        div_ok    = (cfg_div != '0);
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
        cfg_fire = cfg_valid && cfg_ready;
        for (int i = 0; i < N_CH; i++) begin
            wr[i] = cfg_fire && ch_ok && div_ok && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && !(ch_ok && div_ok);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] div_act;
        logic [WIDTH-1:0] div_sh;
        logic             mode_act;
        logic             mode_sh;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             bnd;

        assign bnd        = (count == div_act - WIDTH'(1));
        assign pending[g] = pend;
        assign div_clk[g] = clk_q;
        assign tick[g]    = tick_q;

        always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
            if (!SYS_reset_n) begin
                count    <= '0;
                div_act  <= DIV_RST;
                div_sh   <= DIV_RST;
                mode_act <= MODE_RST;
                mode_sh  <= MODE_RST;
                pend     <= 1'b0;
                clk_q    <= CLK_RST;
                tick_q   <= 1'b0;
            end else begin
                // A write cannot coincide with an apply: cfg_ready is low while pending.
                if (wr[g]) begin
                    div_sh  <= cfg_div;
                    mode_sh <= cfg_mode;
                    pend    <= 1'b1;
                end
                if (!ch_en[g]) begin
                    count  <= '0;
                    tick_q <= 1'b0;
                    clk_q  <= CLK_RST;
                    if (pend) begin
                        div_act  <= div_sh;
                        mode_act <= mode_sh;
                        pend     <= 1'b0;
                    end
                end else begin
                    tick_q <= bnd && mode_act;
                    if (bnd) begin
                        count <= '0;
                        if (!mode_act) begin
                            clk_q <= ~clk_q;
                        end
                        // Apply at count wrap; the event itself still used the old mode.
                        if (pend) begin
                            div_act  <= div_sh;
                            mode_act <= mode_sh;
                            pend     <= 1'b0;
                            if (mode_sh) begin
                                clk_q <= CLK_RST;
                            end
                        end
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: a 4-channel instance for the main
// features and a 3-channel instance for the out-of-range channel reject.
module tb_clk_divider_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ch_en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic       cfg_err;
    logic [3:0] div_clk;
    logic [3:0] tick;

    logic [2:0] ch_en2;
    logic       cfg2_valid;
    logic       cfg2_ready;
    logic [1:0] cfg2_ch;
    logic [7:0] cfg2_div;
    logic       cfg2_mode;
    logic       cfg2_err;
    logic [2:0] div_clk2;
    logic [2:0] tick2;

    int checks   = 0;
    int failures = 0;

    clk_divider_multi #(
        .N_CH(4), .WIDTH(8), .DEFAULT_DIV(4), .DEFAULT_MODE(0), .CLK_INIT(1)
    ) dut (
        .SYS_clk(clk), .SYS_reset_n(rst_n), .ch_en(ch_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
        .div_clk(div_clk), .tick(tick)
    );

    clk_divider_multi #(
        .N_CH(3), .WIDTH(8), .DEFAULT_DIV(4), .DEFAULT_MODE(0), .CLK_INIT(1)
    ) dut3 (
        .SYS_clk(clk), .SYS_reset_n(rst_n), .ch_en(ch_en2),
        .cfg_valid(cfg2_valid), .cfg_ready(cfg2_ready), .cfg_ch(cfg2_ch),
        .cfg_div(cfg2_div), .cfg_mode(cfg2_mode), .cfg_err(cfg2_err),
        .div_clk(div_clk2), .tick(tick2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int dv, input logic md);
        int n;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(dv);
        cfg_mode  = md;
        #1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            $display("FAIL cfg_write_ready ch=%0d got=%b want=1", ch, cfg_ready);
            failures++;
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic exp;
        rst_n = 1'b1; ch_en = 4'hF; ch_en2 = 3'h7;
        cfg_valid = 0; cfg_ch = 0; cfg_div = 0; cfg_mode = 0;
        cfg2_valid = 0; cfg2_ch = 0; cfg2_div = 0; cfg2_mode = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (div_clk !== 4'hF) begin $display("FAIL reset_div_clk got=%h want=f", div_clk); failures++; end
        checks++; if (tick !== 4'h0) begin $display("FAIL reset_tick got=%h want=0", tick); failures++; end
        checks++; if (cfg_err !== 1'b0) begin $display("FAIL reset_cfg_err got=%b want=0", cfg_err); failures++; end
        checks++; if (cfg_ready !== 1'b1) begin $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); failures++; end
        checks++; if (div_clk2 !== 3'h7) begin $display("FAIL reset_div_clk2 got=%h want=7", div_clk2); failures++; end
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++; if (div_clk !== 4'h0) begin $display("FAIL pre_reset_div_clk got=%h want=0", div_clk); failures++; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (div_clk !== 4'hF) begin $display("FAIL midreset_div_clk got=%h want=f", div_clk); failures++; end
        checks++; if (tick !== 4'h0) begin $display("FAIL midreset_tick got=%h want=0", tick); failures++; end
        step();
        rst_n = 1'b1;
        exp = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k % 4 == 0) exp = ~exp;
            checks++;
            if (div_clk !== {4{exp}}) begin
                $display("FAIL reset_period k=%0d got=%h want=%h", k, div_clk, {4{exp}});
                failures++;
            end
        end
    endtask

    task automatic test_pulse();
        ch_en[1] = 1'b0;
        step();
        cfg_write(1, 3, 1'b1);
        checks++; if (cfg_ready !== 1'b0) begin $display("FAIL pulse_pending got=%b want=0", cfg_ready); failures++; end
        step();
        checks++; if (cfg_ready !== 1'b1) begin $display("FAIL pulse_applied got=%b want=1", cfg_ready); failures++; end
        ch_en[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (tick[1] !== (k % 3 == 0)) begin
                $display("FAIL pulse_tick k=%0d got=%b want=%b", k, tick[1], (k % 3 == 0));
                failures++;
            end
            checks++;
            if (div_clk[1] !== 1'b1) begin
                $display("FAIL pulse_div_clk k=%0d got=%b want=1", k, div_clk[1]);
                failures++;
            end
        end
    endtask

    task automatic test_deferred();
        logic exp;
        logic bnd;
        ch_en[0] = 1'b0;
        step();
        cfg_write(0, 10, 1'b0);
        step();
        ch_en[0] = 1'b1;
        exp = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            bnd = (k <= 10) ? (k % 10 == 0) : ((k - 10) % 2 == 0);
            if (bnd) exp = ~exp;
            checks++;
            if (div_clk[0] !== exp) begin
                $display("FAIL deferred_div_clk k=%0d got=%b want=%b", k, div_clk[0], exp);
                failures++;
            end
            if (k >= 4) begin
                checks++;
                if (cfg_ready !== (k >= 10)) begin
                    $display("FAIL deferred_ready k=%0d got=%b want=%b", k, cfg_ready, (k >= 10));
                    failures++;
                end
            end
            if (k == 3) begin
                cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; cfg_mode = 1'b0;
                #1;
                checks++; if (cfg_ready !== 1'b1) begin $display("FAIL deferred_pre_ready got=%b want=1", cfg_ready); failures++; end
            end
            if (k == 4) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_errors();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0; cfg_mode = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin $display("FAIL err_div0_ready got=%b want=1", cfg_ready); failures++; end
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin $display("FAIL err_div0_pulse got=%b want=1", cfg_err); failures++; end
        checks++; if (cfg_ready !== 1'b1) begin $display("FAIL err_div0_no_pending got=%b want=1", cfg_ready); failures++; end
        step();
        checks++; if (cfg_err !== 1'b0) begin $display("FAIL err_div0_width got=%b want=0", cfg_err); failures++; end
        cfg2_valid = 1'b1; cfg2_ch = 2'd3; cfg2_div = 8'd5; cfg2_mode = 1'b0;
        #1;
        checks++; if (cfg2_ready !== 1'b1) begin $display("FAIL err_ch_ready got=%b want=1", cfg2_ready); failures++; end
        step();
        cfg2_valid = 1'b0;
        checks++; if (cfg2_err !== 1'b1) begin $display("FAIL err_ch_pulse got=%b want=1", cfg2_err); failures++; end
        step();
        checks++; if (cfg2_err !== 1'b0) begin $display("FAIL err_ch_width got=%b want=0", cfg2_err); failures++; end
        checks++; if (cfg_err !== 1'b0) begin $display("FAIL err_main_quiet got=%b want=0", cfg_err); failures++; end
    endtask

    task automatic test_independence();
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
        logic [3:0] b;
        ch_en = 4'h0;
        step();
        cfg_write(0, 1, 1'b0);
        cfg_write(1, 2, 1'b1);
        cfg_write(2, 5, 1'b0);
        cfg_write(3, 7, 1'b1);
        step(); step();
        ch_en = 4'hF;
        exp_clk = 4'hF;
        for (int k = 1; k <= 200; k++) begin
            step();
            b[0] = 1'b1;
            b[1] = (k % 2 == 0);
            b[2] = (k <= 55) ? (k % 5 == 0) : ((k - 55) % 3 == 0);
            b[3] = (k % 7 == 0);
            exp_clk[0] = exp_clk[0] ^ b[0];
            exp_clk[2] = exp_clk[2] ^ b[2];
            exp_tick = {b[3], 1'b0, b[1], 1'b0};
            checks++;
            if (div_clk !== exp_clk) begin
                $display("FAIL indep_div_clk k=%0d got=%h want=%h", k, div_clk, exp_clk);
                failures++;
            end
            checks++;
            if (tick !== exp_tick) begin
                $display("FAIL indep_tick k=%0d got=%h want=%h", k, tick, exp_tick);
                failures++;
            end
            if (k == 50) begin
                cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3; cfg_mode = 1'b0;
                #1;
                checks++; if (cfg_ready !== 1'b1) begin $display("FAIL indep_pre_ready got=%b want=1", cfg_ready); failures++; end
            end
            if (k == 51) begin
                cfg_valid = 1'b0;
                checks++; if (cfg_ready !== 1'b0) begin $display("FAIL indep_ch2_pending got=%b want=0", cfg_ready); failures++; end
            end
            if (k == 52) begin
                cfg_ch = 2'd0; #1;
                checks++; if (cfg_ready !== 1'b1) begin $display("FAIL indep_ready_ch0 got=%b want=1", cfg_ready); failures++; end
                cfg_ch = 2'd1; #1;
                checks++; if (cfg_ready !== 1'b1) begin $display("FAIL indep_ready_ch1 got=%b want=1", cfg_ready); failures++; end
                cfg_ch = 2'd3; #1;
                checks++; if (cfg_ready !== 1'b1) begin $display("FAIL indep_ready_ch3 got=%b want=1", cfg_ready); failures++; end
                cfg_ch = 2'd2; #1;
                checks++; if (cfg_ready !== 1'b0) begin $display("FAIL indep_ready_ch2 got=%b want=0", cfg_ready); failures++; end
            end
            if (k == 55) begin
                checks++; if (cfg_ready !== 1'b1) begin $display("FAIL indep_ch2_applied got=%b want=1", cfg_ready); failures++; end
            end
        end
    endtask

    task automatic test_disable_pending();
        logic exp;
        cfg_write(3, 4, 1'b0);
        ch_en[3] = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin $display("FAIL dis_pending got=%b want=0", cfg_ready); failures++; end
        step();
        checks++; if (cfg_ready !== 1'b1) begin $display("FAIL dis_applied got=%b want=1", cfg_ready); failures++; end
        checks++; if (div_clk[3] !== 1'b1) begin $display("FAIL dis_div_clk got=%b want=1", div_clk[3]); failures++; end
        checks++; if (tick[3] !== 1'b0) begin $display("FAIL dis_tick got=%b want=0", tick[3]); failures++; end
        step();
        ch_en[3] = 1'b1;
        exp = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k % 4 == 0) exp = ~exp;
            checks++;
            if (div_clk[3] !== exp) begin
                $display("FAIL dis_reenable_div_clk k=%0d got=%b want=%b", k, div_clk[3], exp);
                failures++;
            end
            checks++;
            if (tick[3] !== 1'b0) begin
                $display("FAIL dis_reenable_tick k=%0d got=%b want=0", k, tick[3]);
                failures++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_deferred();
        test_errors();
        test_independence();
        test_disable_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
